pri_encoder_rr: RTL

Parametrised N-input registered priority encoder with a valid/ack hold handshake. It is the successor to the team's 8-to-3 combinational priority encoder. Requests are sampled, the winning index is registered and held stable until the consumer acknowledges it, and an optional round-robin mode rotates priority after each acknowledged grant. It sits between request sources, such as interrupt lines or channel-ready flags, and a single consumer that services one index at a time.

---
 rtl/pri_encoder_rr.sv | 86 ++++++++
 1 files changed

// File: rtl/pri_encoder_rr.sv
// Registered N-input priority encoder with a valid/ack hold handshake.
// Define PRI_ENC_RR_EN for round-robin arbitration. Otherwise highest index wins.
module pri_encoder_rr #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic         ack,
  output logic         valid,
  output logic [W-1:0] grant_idx,
  output logic [N-1:0] grant_onehot
);

  logic         r_valid;
  logic [W-1:0] r_idx;
  logic [N-1:0] r_onehot;
  logic [W-1:0] w_win;
  logic         w_load;

  assign w_load = en && (req != '0) && (!r_valid || ack);

`ifdef PRI_ENC_RR_EN
  logic [W-1:0] r_last;
  logic [W-1:0] w_last_eff;
  int           w_start;
  int           w_pos;
  logic         w_found;

  // An ack on this edge moves the pointer, so the same-edge reload must already see it.
  assign w_last_eff = (r_valid && ack) ? r_idx : r_last;

  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    w_pos   = 0;
    w_start = (w_last_eff == '0) ? (N - 1) : (int'(w_last_eff) - 1);
    for (int k = 0; k < N; k++) begin
      w_pos = w_start - k;
      if (w_pos < 0) w_pos = w_pos + N;
      if (!w_found && req[w_pos[W-1:0]]) begin
        w_win   = w_pos[W-1:0];
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= '0;
    end else if (r_valid && ack) begin
      r_last <= r_idx;
    end
  end
`else
  always_comb begin
    w_win = '0;
    for (int i = 0; i < N; i++) begin
      if (req[W'(i)]) w_win = W'(i);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_idx    <= '0;
      r_onehot <= '0;
    end else if (w_load) begin
      r_valid  <= 1'b1;
      r_idx    <= w_win;
      r_onehot <= {{(N-1){1'b0}}, 1'b1} << w_win;
    end else if (r_valid && ack) begin
      // Retire: the index stays put, only the one-hot view is cleared.
      r_valid  <= 1'b0;
      r_onehot <= '0;
    end
  end

  assign valid        = r_valid;
  assign grant_idx    = r_idx;
  assign grant_onehot = r_onehot;

endmodule
